// File: rtl/adpll_tdc_decoder.sv
// ADPLL TDC receiver: decodes ripple count plus delay-line taps into an absolute
// phase, differences consecutive samples into tdc_word and tracks channel lock.
module adpll_tdc_decoder #(
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [6:0]  ripple_count,
  input  logic [15:0] phase,
  input  logic [11:0] fcw,
  output logic [11:0] tdc_word,
  output logic        tdc_valid,
  output logic        channel_lock
);

  typedef enum logic [1:0] {IDLE, FILL, PRIME, RUN} state_t;

  localparam logic [7:0] LOCK_SAT = 8'(LOCK_CNT);

  function automatic logic [4:0] popcount16(input logic [15:0] taps);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, taps[i]};
    return n;
  endfunction

  // Counting ones instead of locating the edge makes the decode immune to bubbles.
  function automatic logic [4:0] frac_sat(input logic [4:0] ones);
    logic [5:0] dbl;
    dbl = {ones, 1'b0};
    return (dbl > 6'd31) ? 5'd31 : dbl[4:0];
  endfunction

  function automatic logic in_tol(input logic [11:0] word, input logic [11:0] target);
    logic signed [11:0] err;
    logic [11:0]        mag;
    err = $signed(word - target);
    mag = err[11] ? 12'(-err) : 12'(err);
    return ({20'd0, mag} <= 32'(LOCK_TOL));
  endfunction

  state_t      state, state_next;
  logic        load_p, write_word, clear;
  logic [6:0]  s_ripple;
  logic [15:0] s_phase;
  logic [11:0] p_reg, p_new, word_next;
  logic [7:0]  lock_cnt, lock_cnt_next;
  logic        tol_ok, lock_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = FILL;
        FILL:    state_next = PRIME;
        PRIME:   state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    load_p     = en && (state != IDLE);
    write_word = en && ((state == PRIME) || (state == RUN));
    clear      = !en || (state == IDLE);
  end

  // Stage 0: raw TDC sample capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ripple <= '0;
      s_phase  <= '0;
    end else if (en) begin
      s_ripple <= ripple_count;
      s_phase  <= phase;
    end
  end

  always_comb begin
    p_new     = {s_ripple, frac_sat(popcount16(s_phase))};
    word_next = p_new - p_reg;
    tol_ok    = in_tol(word_next, fcw);
    if (!tol_ok)                 lock_cnt_next = '0;
    else if (lock_cnt >= LOCK_SAT) lock_cnt_next = lock_cnt;
    else                         lock_cnt_next = lock_cnt + 8'd1;
    lock_hit  = tol_ok && (lock_cnt_next == LOCK_SAT);
  end

  // Stage 1: phase difference and lock tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg        <= '0;
      tdc_word     <= '0;
      tdc_valid    <= 1'b0;
      lock_cnt     <= '0;
      channel_lock <= 1'b0;
    end else if (clear) begin
      p_reg        <= '0;
      tdc_word     <= '0;
      tdc_valid    <= 1'b0;
      lock_cnt     <= '0;
      channel_lock <= 1'b0;
    end else begin
      if (load_p) p_reg <= p_new;
      if (write_word) begin
        tdc_word  <= word_next;
        tdc_valid <= 1'b1;
        lock_cnt  <= lock_cnt_next;
        if (lock_hit) channel_lock <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adpll_tdc_decoder.sv
// Scoreboard bench for adpll_tdc_decoder: directed sample bursts push expected
// words into a queue, an independent monitor pops and compares each valid word.
module tb_adpll_tdc_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [6:0]  ripple_count = '0;
  logic [15:0] phase = '0;
  logic [11:0] fcw = '0;
  logic [11:0] tdc_word;
  logic        tdc_valid;
  logic        channel_lock;

  typedef struct packed {
    logic [11:0] word;
    logic        lock;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_cnt = 0;
  logic m_lock = 1'b0;

  adpll_tdc_decoder #(.LOCK_TOL(2), .LOCK_CNT(16)) dut (
    .clk(clk), .rst(rst), .en(en), .ripple_count(ripple_count), .phase(phase),
    .fcw(fcw), .tdc_word(tdc_word), .tdc_valid(tdc_valid), .channel_lock(channel_lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected lock flag follows the word stream of the current burst.
  task automatic push_word(input logic [11:0] w);
    int   d;
    exp_t e;
    d = int'(w) - int'(fcw);
    if (d > 2047) d -= 4096;
    else if (d < -2048) d += 4096;
    if (d <= 2 && d >= -2) begin
      if (m_cnt < 16) m_cnt++;
      if (m_cnt == 16) m_lock = 1'b1;
    end else begin
      m_cnt = 0;
    end
    e.word = w;
    e.lock = m_lock;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_lock = 1'b0;
  endtask

  task automatic send(input logic [6:0] r, input logic [15:0] ph, input bit has_word,
                      input logic [11:0] w, input bit chk_warmup);
    @(negedge clk);
    if (chk_warmup) check("warmup_valid", 32'(tdc_valid), 32'd0);
    ripple_count = r;
    phase        = ph;
    en           = 1'b1;
    if (has_word) push_word(w);
  endtask

  // One extra edge lets the last word be written, then en drops.
  task automatic end_burst(input logic [6:0] r);
    send(r, 16'h0000, 1'b0, 12'd0, 1'b0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_valid", 32'(tdc_valid), 32'd0);
    check("en_drop_word", 32'(tdc_word), 32'd0);
    check("en_drop_lock", 32'(channel_lock), 32'd0);
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (tdc_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got word %0d, expected no word", tdc_word);
        end else begin
          e = q.pop_front();
          check("word", 32'(tdc_word), 32'(e.word));
          check("lock", 32'(channel_lock), 32'(e.lock));
        end
      end else begin
        check("idle_outputs", {19'd0, tdc_word, channel_lock}, 32'd0);
      end
    end
  end

  initial begin : stimulus
    logic [15:0] ph2[30];
    logic [11:0] w2[30];
    logic [6:0]  r3[9];
    logic [15:0] ph3[9];
    logic [11:0] w3[9];

    ph2 = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF,
            16'h00FF, 16'h00FF, 16'h00FF, 16'h1FFF, 16'h0FFF, 16'h1FFF, 16'h1FFF,
            16'h3FFF, 16'h1FFF, 16'h0FFF, 16'h0FFF, 16'h0FFF, 16'h0FFF, 16'h0FFF,
            16'h0FFF, 16'h0FFF, 16'h0FFF, 16'h0FFF, 16'h0FFF, 16'h0FFF, 16'h0003,
            16'h0FFF, 16'h0FFF};
    w2  = '{12'd0, 12'd1280, 12'd1280, 12'd1280, 12'd1280, 12'd1280, 12'd1280,
            12'd1280, 12'd1280, 12'd1280, 12'd1290, 12'd1278, 12'd1282, 12'd1280,
            12'd1282, 12'd1278, 12'd1278, 12'd1280, 12'd1280, 12'd1280, 12'd1280,
            12'd1280, 12'd1280, 12'd1280, 12'd1280, 12'd1280, 12'd1280, 12'd1260,
            12'd1300, 12'd1280};
    r3  = '{7'd120, 7'd32, 7'd0, 7'd127, 7'd10, 7'd20, 7'd30, 7'd30, 7'd30};
    ph3 = '{16'h0003, 16'h03FF, 16'h03FF, 16'h03FF, 16'h00DF, 16'hFFFF, 16'h0000,
            16'h0000, 16'hFFFF};
    w3  = '{12'd0, 12'd1296, 12'd3072, 12'd4064, 12'd346, 12'd337, 12'd289,
            12'd0, 12'd31};

    // Reset with inputs toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_valid", 32'(tdc_valid), 32'd0);
      check("rst_word", 32'(tdc_word), 32'd0);
      check("rst_lock", 32'(channel_lock), 32'd0);
      en           = 1'($urandom_range(0, 1));
      ripple_count = 7'($urandom);
      phase        = 16'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(tdc_valid), 32'd0);
    check("post_rst_word", 32'(tdc_word), 32'd0);

    // Steady count, clean lock on the 16th word
    fcw = 12'd1280;
    for (int k = 0; k < 19; k++)
      send(7'(40 * k), 16'h00FF, k > 0, 12'd1280, k == 1 || k == 2);
    end_burst(7'(40 * 19));

    // Lock restart after an out-of-tolerance word, sticky afterwards
    for (int k = 0; k < 30; k++)
      send(7'(40 * k), ph2[k], k > 0, w2[k], k == 1 || k == 2);
    end_burst(7'(40 * 30));

    // Counter wrap, fraction changes, bubbles and extremes
    fcw = 12'd0;
    for (int k = 0; k < 9; k++)
      send(r3[k], ph3[k], k > 0, w3[k], k == 1 || k == 2);
    end_burst(7'd40);

    // Asynchronous reset in the middle of RUN
    fcw = 12'd1280;
    send(7'd0, 16'h00FF, 1'b0, 12'd0, 1'b0);
    send(7'd40, 16'h00FF, 1'b1, 12'd1280, 1'b1);
    send(7'd80, 16'h00FF, 1'b1, 12'd1280, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    model_reset();
    #1;
    check("async_rst_valid", 32'(tdc_valid), 32'd0);
    check("async_rst_word", 32'(tdc_word), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    send(7'd5, 16'hFFFF, 1'b0, 12'd0, 1'b0);
    send(7'd45, 16'hFFFF, 1'b1, 12'd1280, 1'b1);
    send(7'd85, 16'h0000, 1'b1, 12'd1249, 1'b1);
    end_burst(7'd0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adpll_tdc_decoder.md
# adpll_tdc_decoder

Digital receiver for the analog TDC interface of the ADPLL. Samples the analog TDC outputs on every reference clock edge: the free-running 7-bit CKV ripple counter and the 16-tap delay-line phase code. Decodes them into an absolute fixed-point phase and differences consecutive samples into the 12-bit `tdc_word`, the number of CKV periods per reference cycle. It also checks `tdc_word` against the frequency command word and raises a sticky `channel_lock` once the loop has settled.

## Interface
Parameters:
- `LOCK_TOL`, 2: maximum allowed |tdc_word − fcw| for a word to count as in tolerance (unsigned, in LSBs).
- `LOCK_CNT`, 16: number of consecutive in-tolerance valid words required to assert lock (≥1, ≤255).

Ports:
- `clk`  in  1  reference clock (FREF); all logic on posedge.
- `rst`  in  1  reset; asynchronous and active-high, clears all state.
- `en`  in  1  decoder enable; low forces IDLE.
- `ripple_count`  in  7  CKV edge counter from the analog TDC, modulo 128.
- `phase`  in  16  delay-line tap code from the analog TDC; nominally a thermometer from the LSB, bubbles possible.
- `fcw`  in  12  expected tdc_word for the selected channel, same format as tdc_word.
- `tdc_word`  out  12  {int[6:0], frac[4:0]}: CKV periods per FREF cycle, unsigned, modulo 4096.
- `tdc_valid`  out  1  tdc_word holds a valid difference this cycle.
- `channel_lock`  out  1  sticky lock indication.

## Operation
- Input stage: `s_ripple`/`s_phase` register `ripple_count`/`phase` on every posedge while `en`=1.
- Fraction decode, bubble tolerant:
  - ones = popcount(s_phase), range 0..16.
  - frac = min(2·ones, 31), 5 bits; all-ones therefore maps to 31, not a carry.
- Absolute phase: `p_new` = {s_ripple, frac}, 12 bits.
- Difference: `tdc_word` = `p_new` − `p_reg` modulo 4096. Counter wrap needs no special handling; an integer delta ≥128 aliases, by design.
- FSM states (`en`=0 at any edge moves to IDLE from any state):
  - IDLE: outputs and counters cleared. Edge with `en`=1 captures sample 0 → FILL.
  - FILL: `p_reg` ← p_new(sample 0) → PRIME.
  - PRIME: `p_reg` ← p_new, `tdc_word` ← difference, `tdc_valid` ← 1 → RUN.
  - RUN: same update every edge; `tdc_valid` stays 1.
- Lock detector, evaluated on each word written in PRIME/RUN:
  - err = tdc_word − fcw, interpreted as 12-bit two's complement; |err| ≤ LOCK_TOL means in tolerance.
  - In tolerance: `lock_cnt` increments, saturating at LOCK_CNT. Out of tolerance: `lock_cnt` ← 0.
  - `channel_lock` ← 1 on the edge that writes the LOCK_CNT-th consecutive in-tolerance word.
  - `channel_lock` is sticky: cleared only by `rst` or a return to IDLE. Out-of-tolerance words after lock do not clear it.
- `fcw` is sampled combinationally at each comparison. Changing it does not reset `lock_cnt`.

## Timing
- Reset values: `tdc_word`=0, `tdc_valid`=0, `channel_lock`=0, `lock_cnt`=0, `p_reg`=0, `s_*`=0, state IDLE.
- Latency: the first enabled edge (E0) captures sample 0. `tdc_valid` rises after E2, with `tdc_word` = P1 − P0. From then on, the word after edge Ek is P(k−1) − P(k−2): two FREF cycles from sampling to output.
- Lock timing: `channel_lock` rises in the same edge as the word that completes the run. For LOCK_CNT=16 and an all-in-tolerance stream, this is after E17, at the earliest.
- `en` falling: at the first edge with `en`=0, every output and counter clears simultaneously and the state goes to IDLE. Re-enabling repeats FILL/PRIME; no stale `p_reg` is reused.
- `rst` mid-RUN: outputs clear immediately and asynchronously. Operation resumes from IDLE at the first edge after release with `en`=1.
- Simultaneous: lock comparison uses the word being written in the same edge, not the previous one.

## Test plan
- Reset: assert `rst` with random inputs toggling → all outputs 0 during reset and on the first edge after release with `en`=0.
- Steady count: ripple steps +40 per cycle and `phase`=16'h00FF (frac 16) → `tdc_valid` high after E2, `tdc_word`=1280 every cycle.
- Wrap and fraction change: ripple 120→32 with frac 4→20 → `tdc_word`=1296 (40·32+16). Ripple 0→127 with equal frac → 4064.
- Bubbles/extremes: `phase`=16'h00DF → frac 14; 16'hFFFF → frac 31; 16'h0000 → frac 0. Check the word arithmetic for each.
- Lock: `fcw`=1280, LOCK_CNT=16, words within 1278..1282 → `channel_lock` rises with the 16th valid word. Inject 1290 as the 10th word → `lock_cnt` restarts and lock rises with the 26th word. A later 1300 leaves lock high.
- Enable drop: deassert `en` in RUN with lock high → next edge `tdc_valid`=0, `channel_lock`=0, `tdc_word`=0. Re-enable → the first valid word appears two edges later with no stale difference.
